// File: rtl/seq_alu.sv
// Registered ALU with a valid/ready input handshake.
// Variable shift and multiply run as multi-cycle FSM ops.
module seq_alu #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inValid,
    output logic             inReady,
    input  logic [2:0]       opSel,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    output logic             outValid,
    output logic [WIDTH-1:0] result,
    output logic             carryFlag,
    output logic             zeroFlag
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        MULT
    } state_t;

    state_t state, state_nx;

    // One extra bit so the counter can hold WIDTH for multiply
    logic [SHW:0]         count, count_nx;
    logic [2*WIDTH-1:0]   acc, acc_nx;
    logic [2*WIDTH-1:0]   mcand, mcand_nx;
    logic [WIDTH-1:0]     work, work_nx;
    logic [WIDTH-1:0]     mplier, mplier_nx;
    logic                 wcarry, wcarry_nx;
    logic [WIDTH-1:0]     result_nx;
    logic                 carry_nx;
    logic                 load;
    logic [WIDTH:0]       sum;
    logic [WIDTH:0]       diff;

    assign inReady = (state == IDLE);
    assign sum     = {1'b0, opA} + {1'b0, opB};
    assign diff    = {1'b0, opA} - {1'b0, opB};

    always_comb begin
        state_nx  = state;
        count_nx  = count;
        acc_nx    = acc;
        mcand_nx  = mcand;
        work_nx   = work;
        mplier_nx = mplier;
        wcarry_nx = wcarry;
        result_nx = result;
        carry_nx  = carryFlag;
        load      = 1'b0;
        unique case (state)
            IDLE: begin
                if (inValid) begin
                    unique case (opSel)
                        3'b000: begin
                            load      = 1'b1;
                            result_nx = opA & opB;
                            carry_nx  = 1'b0;
                        end
                        3'b001: begin
                            load      = 1'b1;
                            result_nx = opA ^ opB;
                            carry_nx  = 1'b0;
                        end
                        3'b010: begin
                            load      = 1'b1;
                            result_nx = sum[WIDTH-1:0];
                            carry_nx  = sum[WIDTH];
                        end
                        3'b011: begin
                            load      = 1'b1;
                            result_nx = {opA[WIDTH-2:0], 1'b0};
                            carry_nx  = opA[WIDTH-1];
                        end
                        3'b100: begin
                            load      = 1'b1;
                            result_nx = diff[WIDTH-1:0];
                            carry_nx  = diff[WIDTH];
                        end
                        3'b101: begin
                            load      = 1'b1;
                            result_nx = opA | opB;
                            carry_nx  = 1'b0;
                        end
                        3'b110: begin
                            state_nx  = SHIFT;
                            count_nx  = {1'b0, opB[SHW-1:0]};
                            work_nx   = opA;
                            wcarry_nx = 1'b0;
                        end
                        3'b111: begin
                            state_nx  = MULT;
                            count_nx  = (SHW+1)'(WIDTH);
                            acc_nx    = '0;
                            mcand_nx  = {{WIDTH{1'b0}}, opA};
                            mplier_nx = opB;
                        end
                    endcase
                end
            end
            SHIFT: begin
                if (count != '0) begin
                    wcarry_nx = work[WIDTH-1];
                    work_nx   = {work[WIDTH-2:0], 1'b0};
                    count_nx  = count - 1'b1;
                end else begin
                    load      = 1'b1;
                    result_nx = work;
                    carry_nx  = wcarry;
                    state_nx  = IDLE;
                end
            end
            MULT: begin
                if (count != '0) begin
                    if (mplier[0]) acc_nx = acc + mcand;
                    mcand_nx  = {mcand[2*WIDTH-2:0], 1'b0};
                    mplier_nx = {1'b0, mplier[WIDTH-1:1]};
                    count_nx  = count - 1'b1;
                end else begin
                    load      = 1'b1;
                    result_nx = acc[WIDTH-1:0];
                    carry_nx  = |acc[2*WIDTH-1:WIDTH];
                    state_nx  = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            count     <= '0;
            acc       <= '0;
            mcand     <= '0;
            work      <= '0;
            mplier    <= '0;
            wcarry    <= 1'b0;
            result    <= '0;
            carryFlag <= 1'b0;
            zeroFlag  <= 1'b1;
            outValid  <= 1'b0;
        end else begin
            state    <= state_nx;
            count    <= count_nx;
            acc      <= acc_nx;
            mcand    <= mcand_nx;
            work     <= work_nx;
            mplier   <= mplier_nx;
            wcarry   <= wcarry_nx;
            outValid <= load;
            if (load) begin
                result    <= result_nx;
                carryFlag <= carry_nx;
                zeroFlag  <= (result_nx == '0);
            end
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu at WIDTH=8.
// Inputs and samples both happen on the falling clock edge.
module tb_seq_alu;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         inValid = 1'b0;
    logic         inReady;
    logic [2:0]   opSel = 3'b000;
    logic [W-1:0] opA = '0;
    logic [W-1:0] opB = '0;
    logic         outValid;
    logic [W-1:0] result;
    logic         carryFlag;
    logic         zeroFlag;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_alu #(.WIDTH(W)) dut (
        .clk(clk),
        .rst(rst),
        .inValid(inValid),
        .inReady(inReady),
        .opSel(opSel),
        .opA(opA),
        .opB(opB),
        .outValid(outValid),
        .result(result),
        .carryFlag(carryFlag),
        .zeroFlag(zeroFlag)
    );

    task automatic drive(input logic [2:0] op,
                         input logic [W-1:0] a,
                         input logic [W-1:0] b);
        inValid = 1'b1;
        opSel   = op;
        opA     = a;
        opB     = b;
    endtask

    // Called on the first falling edge after accept; lat counts edges.
    task automatic wait_done(output int lat, output int rdy_bad);
        lat = 0;
        rdy_bad = 0;
        while (outValid !== 1'b1 && lat < 40) begin
            if (inReady !== 1'b0) rdy_bad++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({inReady, outValid, result, carryFlag, zeroFlag} !==
            {1'b1, 1'b0, 8'h00, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset: got rdy=%b ov=%b r=%h c=%b z=%b",
                     inReady, outValid, result, carryFlag, zeroFlag);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_add();
        drive(3'b010, 8'hF0, 8'h20);
        @(negedge clk);
        inValid = 1'b0;
        checks++;
        if ({outValid, result, carryFlag, zeroFlag, inReady} !==
            {1'b1, 8'h10, 1'b1, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL add: got ov=%b r=%h c=%b z=%b rdy=%b exp 1 10 1 0 1",
                     outValid, result, carryFlag, zeroFlag, inReady);
        end
        @(negedge clk);
        checks++;
        if (outValid !== 1'b0 || result !== 8'h10) begin
            errors++;
            $display("FAIL add_hold: got ov=%b r=%h exp 0 10",
                     outValid, result);
        end
    endtask

    task automatic test_sub();
        drive(3'b100, 8'h05, 8'h05);
        @(negedge clk);
        checks++;
        if ({outValid, result, carryFlag, zeroFlag} !==
            {1'b1, 8'h00, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL sub_eq: got ov=%b r=%h c=%b z=%b exp 1 00 0 1",
                     outValid, result, carryFlag, zeroFlag);
        end
        drive(3'b100, 8'h03, 8'h05);
        @(negedge clk);
        inValid = 1'b0;
        checks++;
        if ({outValid, result, carryFlag, zeroFlag} !==
            {1'b1, 8'hFE, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL sub_borrow: got ov=%b r=%h c=%b z=%b exp 1 fe 1 0",
                     outValid, result, carryFlag, zeroFlag);
        end
        @(negedge clk);
    endtask

    task automatic test_shlv();
        int lat, bad;
        drive(3'b110, 8'h81, 8'h0B);
        @(negedge clk);
        inValid = 1'b0;
        wait_done(lat, bad);
        checks++;
        if (lat != 4 || bad != 0) begin
            errors++;
            $display("FAIL shlv3_timing: got lat=%0d rdy_bad=%0d exp 4 0",
                     lat, bad);
        end
        checks++;
        if ({result, carryFlag, zeroFlag, inReady} !==
            {8'h08, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL shlv3_value: got r=%h c=%b z=%b rdy=%b exp 08 0 0 1",
                     result, carryFlag, zeroFlag, inReady);
        end
        @(negedge clk);
        checks++;
        if (outValid !== 1'b0) begin
            errors++;
            $display("FAIL shlv3_pulse: got ov=%b exp 0", outValid);
        end
        drive(3'b110, 8'h81, 8'h00);
        @(negedge clk);
        inValid = 1'b0;
        wait_done(lat, bad);
        checks++;
        if (lat != 1 || bad != 0 || result !== 8'h81 || carryFlag !== 1'b0) begin
            errors++;
            $display("FAIL shlv0: got lat=%0d bad=%0d r=%h c=%b exp 1 0 81 0",
                     lat, bad, result, carryFlag);
        end
        @(negedge clk);
    endtask

    task automatic test_mul();
        int lat, bad;
        drive(3'b111, 8'h10, 8'h10);
        @(negedge clk);
        drive(3'b010, 8'h01, 8'h01);
        wait_done(lat, bad);
        checks++;
        if (lat != 9 || bad != 0) begin
            errors++;
            $display("FAIL mul_timing: got lat=%0d rdy_bad=%0d exp 9 0",
                     lat, bad);
        end
        checks++;
        if ({result, carryFlag, zeroFlag, inReady} !==
            {8'h00, 1'b1, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL mul_ovf: got r=%h c=%b z=%b rdy=%b exp 00 1 1 1",
                     result, carryFlag, zeroFlag, inReady);
        end
        @(negedge clk);
        inValid = 1'b0;
        checks++;
        if ({outValid, result, carryFlag} !== {1'b1, 8'h02, 1'b0}) begin
            errors++;
            $display("FAIL held_add: got ov=%b r=%h c=%b exp 1 02 0",
                     outValid, result, carryFlag);
        end
        @(negedge clk);
        drive(3'b111, 8'h0F, 8'h11);
        @(negedge clk);
        inValid = 1'b0;
        wait_done(lat, bad);
        checks++;
        if (lat != 9 || result !== 8'hFF || carryFlag !== 1'b0 ||
            zeroFlag !== 1'b0) begin
            errors++;
            $display("FAIL mul_ff: got lat=%0d r=%h c=%b z=%b exp 9 ff 0 0",
                     lat, result, carryFlag, zeroFlag);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        drive(3'b000, 8'hCC, 8'hAA);
        @(negedge clk);
        drive(3'b001, 8'hCC, 8'hAA);
        checks++;
        if ({outValid, result, carryFlag} !== {1'b1, 8'h88, 1'b0}) begin
            errors++;
            $display("FAIL b2b_and: got ov=%b r=%h c=%b exp 1 88 0",
                     outValid, result, carryFlag);
        end
        @(negedge clk);
        drive(3'b011, 8'h80, 8'h00);
        checks++;
        if ({outValid, result, carryFlag} !== {1'b1, 8'h66, 1'b0}) begin
            errors++;
            $display("FAIL b2b_xor: got ov=%b r=%h c=%b exp 1 66 0",
                     outValid, result, carryFlag);
        end
        @(negedge clk);
        inValid = 1'b0;
        checks++;
        if ({outValid, result, carryFlag, zeroFlag} !==
            {1'b1, 8'h00, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL b2b_shl1: got ov=%b r=%h c=%b z=%b exp 1 00 1 1",
                     outValid, result, carryFlag, zeroFlag);
        end
        @(negedge clk);
        checks++;
        if (outValid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_end: got ov=%b exp 0", outValid);
        end
    endtask

    task automatic test_rst_mid();
        int seen;
        drive(3'b111, 8'hFF, 8'hFF);
        @(negedge clk);
        inValid = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({inReady, outValid, result, carryFlag, zeroFlag} !==
            {1'b1, 1'b0, 8'h00, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL rst_mid: got rdy=%b ov=%b r=%h c=%b z=%b",
                     inReady, outValid, result, carryFlag, zeroFlag);
        end
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (outValid !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0 || inReady !== 1'b1) begin
            errors++;
            $display("FAIL rst_no_out: got pulses=%0d rdy=%b exp 0 1",
                     seen, inReady);
        end
        drive(3'b010, 8'h01, 8'h01);
        @(negedge clk);
        inValid = 1'b0;
        checks++;
        if ({outValid, result, carryFlag, zeroFlag} !==
            {1'b1, 8'h02, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL rst_recover: got ov=%b r=%h c=%b z=%b exp 1 02 0 0",
                     outValid, result, carryFlag, zeroFlag);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_shlv();
        test_mul();
        test_back_to_back();
        test_rst_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
